leve1_lsu_wb: RTL and testbench
===============================

# leve1_lsu_wb

Memory-access / write-back stage of the LEVE1 pipeline. It accepts executed instructions from EX, performs load/store transactions on the data-memory port with a request/acknowledge/response handshake, and aligns and extends load data. It then drives the write-back interface consumed by the decode stage: register-file write, CSR write and retired PC.

## Interface
- XLEN, 64, datapath width (from `defs.vh` `XLEN`); DSTRB width is XLEN/8.
- CLK  in  1  clock.
- RSTn  in  1  reset; asynchronous, active-low.
- IVALID  in  1  EX result valid.
- IREADY  out  1  stage can accept; high only in IDLE.
- IPC  in  XLEN  PC of the incoming instruction.
- IINSTR  in  32  instruction word.
- IRD  in  XLEN  ALU result; effective address for loads and stores.
- IRS2  in  XLEN  store data.
- ICSRD  in  XLEN  CSR write data.
- DREQ  out  1  data request; held until DACK.
- DWE  out  1  1 = store, 0 = load.
- DADDR  out  XLEN  address, aligned down to 8 bytes.
- DWDATA  out  XLEN  store data, lane-shifted.
- DSTRB  out  XLEN/8  byte enables.
- DACK  in  1  request accepted.
- DRVALID  in  1  load data valid.
- DRDATA  in  XLEN  load data.
- WB_OVALID  out  1  retire pulse.
- WB_OPC  out  XLEN  retired PC.
- WB_OWE  out  1  register-file write enable.
- WB_OINSTR  out  32  retired instruction.
- WB_ORD  out  XLEN  register write data.
- WB_OCSRD  out  XLEN  CSR write data.
- MISALIGN  out  1  one-cycle pulse for a misaligned access.

## Operation
- FSM states: IDLE, REQ, WAIT.
- **IDLE, accept** (IVALID && IREADY):
  - Non-memory instruction: register the WB_* outputs; stay in IDLE.
  - LOAD (0000011) or STORE (0100011), aligned: capture the operands; go to REQ.
  - Misaligned access: retire immediately with WB_OWE=0 and pulse MISALIGN; no DREQ.
- **Alignment rule** (size from funct3[1:0]): half needs addr[0]=0; word needs addr[1:0]=0; double needs addr[2:0]=0.
- **REQ:** DREQ=1 with stable DWE/DADDR/DWDATA/DSTRB. On DACK:
  - Store: retire; go to IDLE.
  - Load: go to WAIT.
- **WAIT:** on DRVALID, extract lane addr[2:0] and extend by funct3: 000 LB and 100 LBU are 8-bit; 001 LH and 101 LHU are 16-bit; 010 LW and 110 LWU are 32-bit; 011 LD is 64-bit. Signed forms sign-extend, unsigned forms zero-extend. Then retire and go to IDLE.
- **Store encoding:**
  - DSTRB = {01,03,0F,FF}[size] << addr[2:0].
  - DWDATA = IRS2 << (8*addr[2:0]).
- **WB_OWE=1** for opcodes LUI, AUIPC, JAL, JALR, OP-IMM, OP, OP-IMM-32, OP-32, LOAD, and SYSTEM with funct3≠0. It is 0 for all other opcodes and for misaligned accesses.
- **WB_ORD:** load data for loads, IRD otherwise.
- **WB_OCSRD:** ICSRD, passed through unchanged.
- **Ignored inputs:** DRVALID outside WAIT, and DACK outside REQ.

## Timing
- **Reset:** all outputs 0 (IREADY is the only exception), state IDLE. IREADY=1 from reset.
- **Reset mid-transaction:** DREQ and WB_OVALID drop asynchronously and the transaction is abandoned.
- **Non-memory latency:** accept at cycle T, WB_OVALID at T+1. Sustains 1 instruction/cycle back-to-back.
- **Store:** accept at T, DREQ from T+1. With DACK at cycle A, WB_OVALID at A+1.
- **Load:** DACK at cycle A; DRVALID is counted at cycle A+1 or later. With DRVALID at R, WB_OVALID at R+1.
- **IREADY:** low from the cycle after a memory accept until the cycle after retire, when the state has returned to IDLE.
- **WB_OVALID:** exactly one cycle per instruction. WB_O* hold their values until the next retire.
- **Upstream contract:** the sender holds its inputs while IREADY=0.

## Structure
- **leve1_pkg:**
  - opcode constants;
  - load/store funct3 constants;
  - FSM state enum;
  - size-to-strobe constants.
- **Sub-module leve1_lsu_align (combinational):**
  - store path: strobe and shift generation;
  - load path: lane extraction plus sign/zero extension.
- **Top level:** FSM and registers.

## Test plan
- **ADDI x5,x0,42:** IINSTR=0x02A00293, IRD=0x2A → WB_OVALID at T+1, WB_OWE=1, WB_ORD=0x2A, DREQ never asserted.
- **SB, address 0x1003, IRS2=0xAB, DACK 3 cycles late:**
  - DSTRB=0x08 and DWDATA[31:24]=0xAB, held stable until DACK.
  - IREADY=0 throughout.
  - WB_OWE=0.
- **LB/LBU, address 0x1005, DRDATA=0x0000800000000000:**
  - LB: WB_ORD=0xFFFFFFFFFFFFFF80.
  - LBU: WB_ORD=0x80.
  - For both, WB_OVALID is asserted one cycle after DRVALID.
- **LW at 0x1002:** no DREQ, MISALIGN pulses once, WB_OVALID=1 with WB_OWE=0 at T+1.
- **RSTn asserted in WAIT, then DRVALID after release:** outputs are 0 during reset, the late DRVALID is ignored, and IREADY=1 after release.
- **Three back-to-back ADDs, then LD with DACK and DRVALID immediate:**
  - The ADDs produce three consecutive WB_OVALID pulses.
  - The LD retires 3 cycles after accept (REQ/DACK, WAIT/DRVALID, retire).

Source files
------------

// File: rtl/leve1_pkg.sv
// Shared constants, state type and small decode helpers for the LEVE1 memory/write-back stage.
// Opcode, funct3 and strobe encodings follow the RV64 base ISA.
package leve1_pkg;

  localparam int XLEN  = 64;
  localparam int STRBW = XLEN / 8;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [STRBW-1:0] STRB_B = 8'h01;
  localparam logic [STRBW-1:0] STRB_H = 8'h03;
  localparam logic [STRBW-1:0] STRB_W = 8'h0F;
  localparam logic [STRBW-1:0] STRB_D = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_e;

  function automatic logic [STRBW-1:0] size_strobe(input logic [1:0] size);
    logic [STRBW-1:0] strb;
    case (size)
      SZ_B:    strb = STRB_B;
      SZ_H:    strb = STRB_H;
      SZ_W:    strb = STRB_W;
      default: strb = STRB_D;
    endcase
    return strb;
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] addr_lo);
    logic ok;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = (addr_lo[0] == 1'b0);
      SZ_W:    ok = (addr_lo[1:0] == 2'b00);
      default: ok = (addr_lo == 3'b000);
    endcase
    return ok;
  endfunction

  // SYSTEM with funct3 = 0 is ECALL/EBREAK/xRET, which never write rd.
  function automatic logic writes_rd(input logic [6:0] opcode, input logic [2:0] funct3);
    logic we;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_OP_IMM, OPC_OP, OPC_OP_IMM_32, OPC_OP_32,
      OPC_LOAD: we = 1'b1;
      OPC_SYSTEM: we = (funct3 != 3'b000);
      default:    we = 1'b0;
    endcase
    return we;
  endfunction

endpackage

// File: rtl/leve1_lsu_wb_if.sv
// Bundles the EX input, data-memory port and write-back signals of the LSU/WB stage.
// master is the stage itself; slave is the surrounding pipeline and memory.
interface leve1_lsu_wb_if;
  import leve1_pkg::*;

  logic             IVALID;
  logic             IREADY;
  logic [XLEN-1:0]  IPC;
  logic [31:0]      IINSTR;
  logic [XLEN-1:0]  IRD;
  logic [XLEN-1:0]  IRS2;
  logic [XLEN-1:0]  ICSRD;

  logic             DREQ;
  logic             DWE;
  logic [XLEN-1:0]  DADDR;
  logic [XLEN-1:0]  DWDATA;
  logic [STRBW-1:0] DSTRB;
  logic             DACK;
  logic             DRVALID;
  logic [XLEN-1:0]  DRDATA;

  logic             WB_OVALID;
  logic [XLEN-1:0]  WB_OPC;
  logic             WB_OWE;
  logic [31:0]      WB_OINSTR;
  logic [XLEN-1:0]  WB_ORD;
  logic [XLEN-1:0]  WB_OCSRD;
  logic             MISALIGN;

  modport master (
    input  IVALID, IPC, IINSTR, IRD, IRS2, ICSRD,
    output IREADY,
    output DREQ, DWE, DADDR, DWDATA, DSTRB,
    input  DACK, DRVALID, DRDATA,
    output WB_OVALID, WB_OPC, WB_OWE, WB_OINSTR, WB_ORD, WB_OCSRD, MISALIGN
  );

  modport slave (
    output IVALID, IPC, IINSTR, IRD, IRS2, ICSRD,
    input  IREADY,
    input  DREQ, DWE, DADDR, DWDATA, DSTRB,
    output DACK, DRVALID, DRDATA,
    input  WB_OVALID, WB_OPC, WB_OWE, WB_OINSTR, WB_ORD, WB_OCSRD, MISALIGN
  );

endinterface

// File: rtl/leve1_lsu_align.sv
// Combinational lane logic: store strobe/data shifting and load lane extraction with extension.
// Callers guarantee the offset is naturally aligned for the access size.
module leve1_lsu_align
  import leve1_pkg::*;
(
  input  logic [1:0]       st_size,
  input  logic [2:0]       st_offset,
  input  logic [XLEN-1:0]  st_data,
  output logic [STRBW-1:0] st_strb,
  output logic [XLEN-1:0]  st_wdata,
  input  logic [2:0]       ld_funct3,
  input  logic [2:0]       ld_offset,
  input  logic [XLEN-1:0]  ld_data,
  output logic [XLEN-1:0]  ld_result
);

  logic [XLEN-1:0] ld_shifted;

  assign st_strb    = size_strobe(st_size) << st_offset;
  assign st_wdata   = st_data << {st_offset, 3'b000};
  assign ld_shifted = ld_data >> {ld_offset, 3'b000};

  always_comb begin
    ld_result = ld_shifted;
    case (ld_funct3)
      F3_LB:  ld_result = {{(XLEN-8){ld_shifted[7]}}, ld_shifted[7:0]};
      F3_LBU: ld_result = {{(XLEN-8){1'b0}}, ld_shifted[7:0]};
      F3_LH:  ld_result = {{(XLEN-16){ld_shifted[15]}}, ld_shifted[15:0]};
      F3_LHU: ld_result = {{(XLEN-16){1'b0}}, ld_shifted[15:0]};
      F3_LW:  ld_result = {{(XLEN-32){ld_shifted[31]}}, ld_shifted[31:0]};
      F3_LWU: ld_result = {{(XLEN-32){1'b0}}, ld_shifted[31:0]};
      default: ld_result = ld_shifted;
    endcase
  end

endmodule

// File: rtl/leve1_lsu_wb.sv
// LEVE1 memory-access / write-back stage: runs load/store handshakes on the data port
// and registers the retire bundle consumed by decode.
module leve1_lsu_wb
  import leve1_pkg::*;
(
  input logic            CLK,
  input logic            RSTn,
  leve1_lsu_wb_if.master bus
);

  lsu_state_e state, state_next;

  logic [6:0] in_opcode;
  logic [2:0] in_funct3;
  logic       in_is_mem;
  logic       in_aligned;

  logic accept_direct;
  logic accept_mem;
  logic retire_store;
  logic retire_load;

  logic [XLEN-1:0] cap_pc;
  logic [31:0]     cap_instr;
  logic [XLEN-1:0] cap_rd;
  logic [XLEN-1:0] cap_csrd;

  logic             dwe_q;
  logic [XLEN-1:0]  daddr_q;
  logic [XLEN-1:0]  dwdata_q;
  logic [STRBW-1:0] dstrb_q;

  logic            wb_valid_q;
  logic [XLEN-1:0] wb_pc_q;
  logic            wb_we_q;
  logic [31:0]     wb_instr_q;
  logic [XLEN-1:0] wb_rd_q;
  logic [XLEN-1:0] wb_csrd_q;
  logic            misalign_q;

  logic [STRBW-1:0] st_strb;
  logic [XLEN-1:0]  st_wdata;
  logic [XLEN-1:0]  ld_result;

  assign in_opcode  = bus.IINSTR[6:0];
  assign in_funct3  = bus.IINSTR[14:12];
  assign in_is_mem  = (in_opcode == OPC_LOAD) || (in_opcode == OPC_STORE);
  assign in_aligned = is_aligned(in_funct3[1:0], bus.IRD[2:0]);

  // Store lanes come from the live inputs at accept; load lanes from the captured instruction.
  leve1_lsu_align u_align (
    .st_size   (in_funct3[1:0]),
    .st_offset (bus.IRD[2:0]),
    .st_data   (bus.IRS2),
    .st_strb   (st_strb),
    .st_wdata  (st_wdata),
    .ld_funct3 (cap_instr[14:12]),
    .ld_offset (cap_rd[2:0]),
    .ld_data   (bus.DRDATA),
    .ld_result (ld_result)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    accept_direct = 1'b0;
    accept_mem    = 1'b0;
    retire_store  = 1'b0;
    retire_load   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.IVALID) begin
          if (in_is_mem && in_aligned) begin
            accept_mem = 1'b1;
            state_next = ST_REQ;
          end else begin
            accept_direct = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (bus.DACK) begin
          if (dwe_q) begin
            retire_store = 1'b1;
            state_next   = ST_IDLE;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (bus.DRVALID) begin
          retire_load = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Memory operands are latched at accept so the request stays stable until DACK.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cap_pc    <= '0;
      cap_instr <= '0;
      cap_rd    <= '0;
      cap_csrd  <= '0;
      dwe_q     <= 1'b0;
      daddr_q   <= '0;
      dwdata_q  <= '0;
      dstrb_q   <= '0;
    end else if (accept_mem) begin
      cap_pc    <= bus.IPC;
      cap_instr <= bus.IINSTR;
      cap_rd    <= bus.IRD;
      cap_csrd  <= bus.ICSRD;
      dwe_q     <= (in_opcode == OPC_STORE);
      daddr_q   <= {bus.IRD[XLEN-1:3], 3'b000};
      dwdata_q  <= st_wdata;
      dstrb_q   <= st_strb;
    end
  end

  // Retire bundle; a misaligned memory op retires like a non-memory op but never writes rd.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wb_valid_q <= 1'b0;
      wb_pc_q    <= '0;
      wb_we_q    <= 1'b0;
      wb_instr_q <= '0;
      wb_rd_q    <= '0;
      wb_csrd_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      wb_valid_q <= accept_direct || retire_store || retire_load;
      misalign_q <= accept_direct && in_is_mem;
      if (accept_direct) begin
        wb_pc_q    <= bus.IPC;
        wb_we_q    <= !in_is_mem && writes_rd(in_opcode, in_funct3);
        wb_instr_q <= bus.IINSTR;
        wb_rd_q    <= bus.IRD;
        wb_csrd_q  <= bus.ICSRD;
      end else if (retire_store || retire_load) begin
        wb_pc_q    <= cap_pc;
        wb_we_q    <= writes_rd(cap_instr[6:0], cap_instr[14:12]);
        wb_instr_q <= cap_instr;
        wb_rd_q    <= retire_load ? ld_result : cap_rd;
        wb_csrd_q  <= cap_csrd;
      end
    end
  end

  assign bus.IREADY    = (state == ST_IDLE);
  assign bus.DREQ      = (state == ST_REQ);
  assign bus.DWE       = dwe_q;
  assign bus.DADDR     = daddr_q;
  assign bus.DWDATA    = dwdata_q;
  assign bus.DSTRB     = dstrb_q;
  assign bus.WB_OVALID = wb_valid_q;
  assign bus.WB_OPC    = wb_pc_q;
  assign bus.WB_OWE    = wb_we_q;
  assign bus.WB_OINSTR = wb_instr_q;
  assign bus.WB_ORD    = wb_rd_q;
  assign bus.WB_OCSRD  = wb_csrd_q;
  assign bus.MISALIGN  = misalign_q;

endmodule

// File: tb/tb_leve1_lsu_wb.sv
// Directed plus randomized bench for leve1_lsu_wb; expectations come from a byte-level
// reference model of the load/store and write-back rules.
module tb_leve1_lsu_wb;
  import leve1_pkg::*;

  logic CLK;
  logic RSTn;
  int   tests;
  int   errors;

  leve1_lsu_wb_if bus ();

  leve1_lsu_wb dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic stepClock();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int refBytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit refAligned(input logic [2:0] f3, input logic [63:0] addr);
    return (addr % refBytes(f3)) == 0;
  endfunction

  function automatic logic [63:0] refLoad(input logic [2:0] f3, input int off, input logic [63:0] data);
    logic [63:0] v;
    int n;
    n = refBytes(f3);
    v = '0;
    for (int k = 0; k < 8; k++)
      if (k < n && off + k < 8) v[8*k +: 8] = data[8*(off+k) +: 8];
    if (f3[2] == 1'b0 && n < 8 && v[8*n-1] == 1'b1)
      for (int k = 0; k < 8; k++)
        if (k >= n) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] refStrb(input logic [2:0] f3, input int off);
    logic [7:0] s;
    s = '0;
    for (int k = 0; k < refBytes(f3); k++)
      if (off + k < 8) s[off+k] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] refWdata(input logic [63:0] rs2, input int off);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k + off < 8; k++) w[8*(off+k) +: 8] = rs2[8*k +: 8];
    return w;
  endfunction

  function automatic bit refOwe(input logic [31:0] instr);
    logic [6:0] op;
    op = instr[6:0];
    if (op == 7'h37 || op == 7'h17 || op == 7'h6F || op == 7'h67 ||
        op == 7'h13 || op == 7'h33 || op == 7'h1B || op == 7'h3B || op == 7'h03)
      return 1'b1;
    if (op == 7'h73) return instr[14:12] != 3'b000;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mkInstr(input logic [6:0] opcode, input logic [2:0] f3);
    logic [31:0] r;
    r = $urandom;
    return {r[31:15], f3, r[11:7], opcode};
  endfunction

  // Runs one instruction end to end: accept, optional memory handshake, retire and hold.
  task automatic applyStimulus(input logic [31:0] instr, input logic [63:0] pc, input logic [63:0] rd,
                               input logic [63:0] rs2, input logic [63:0] csrd, input int ackDelay,
                               input int rvDelay, input logic [63:0] rdata, input bit holdValid);
    bit isLoad, isStore, misal;
    int off;
    logic [63:0] expOrd;
    isLoad  = instr[6:0] == 7'h03;
    isStore = instr[6:0] == 7'h23;
    off     = int'(rd[2:0]);
    misal   = (isLoad || isStore) && !refAligned(instr[14:12], rd);
    expOrd  = rd;
    checkOutput("ireadyBefore", bus.IREADY, 1);
    bus.IVALID = 1'b1;
    bus.IPC    = pc;
    bus.IINSTR = instr;
    bus.IRD    = rd;
    bus.IRS2   = rs2;
    bus.ICSRD  = csrd;
    if (!(isLoad || isStore)) begin
      bus.DACK    = 1'($urandom);
      bus.DRVALID = 1'($urandom);
    end
    stepClock();
    if (!(isLoad || isStore) || misal) begin
      checkOutput("directValid", bus.WB_OVALID, 1);
      checkOutput("directPc", bus.WB_OPC, pc);
      checkOutput("directInstr", bus.WB_OINSTR, instr);
      checkOutput("directOwe", bus.WB_OWE, misal ? 1'b0 : refOwe(instr));
      checkOutput("directOrd", bus.WB_ORD, rd);
      checkOutput("directCsrd", bus.WB_OCSRD, csrd);
      checkOutput("directMisalign", bus.MISALIGN, misal);
      checkOutput("directNoReq", bus.DREQ, 0);
      checkOutput("directIready", bus.IREADY, 1);
      if (holdValid) return;
    end else begin
      bus.IVALID = 1'b0;
      for (int i = 0; i <= ackDelay; i++) begin
        bus.DACK    = (i == ackDelay);
        bus.DRVALID = 1'($urandom);
        checkOutput("reqDreq", bus.DREQ, 1);
        checkOutput("reqDwe", bus.DWE, isStore);
        checkOutput("reqDaddr", bus.DADDR, {rd[63:3], 3'b000});
        if (isStore) begin
          checkOutput("reqDstrb", bus.DSTRB, refStrb(instr[14:12], off));
          checkOutput("reqDwdata", bus.DWDATA, refWdata(rs2, off));
        end
        checkOutput("reqIready", bus.IREADY, 0);
        checkOutput("reqNoRetire", bus.WB_OVALID, 0);
        stepClock();
      end
      bus.DACK    = 1'b0;
      bus.DRVALID = 1'b0;
      if (isLoad) begin
        expOrd = refLoad(instr[14:12], off, rdata);
        for (int i = 0; i <= rvDelay; i++) begin
          bus.DRVALID = (i == rvDelay);
          bus.DRDATA  = (i == rvDelay) ? rdata : {$urandom, $urandom};
          bus.DACK    = 1'($urandom);
          checkOutput("waitNoReq", bus.DREQ, 0);
          checkOutput("waitIready", bus.IREADY, 0);
          checkOutput("waitNoRetire", bus.WB_OVALID, 0);
          stepClock();
        end
        bus.DRVALID = 1'b0;
        bus.DACK    = 1'b0;
      end
      checkOutput("memValid", bus.WB_OVALID, 1);
      checkOutput("memPc", bus.WB_OPC, pc);
      checkOutput("memOwe", bus.WB_OWE, isLoad);
      checkOutput("memOrd", bus.WB_ORD, expOrd);
      checkOutput("memCsrd", bus.WB_OCSRD, csrd);
      checkOutput("memMisalign", bus.MISALIGN, 0);
      checkOutput("memIready", bus.IREADY, 1);
    end
    bus.IVALID  = 1'b0;
    bus.DACK    = 1'b0;
    bus.DRVALID = 1'b0;
    stepClock();
    checkOutput("pulseEnds", bus.WB_OVALID, 0);
    checkOutput("misalignEnds", bus.MISALIGN, 0);
    checkOutput("ordHeld", bus.WB_ORD, expOrd);
    checkOutput("pcHeld", bus.WB_OPC, pc);
  endtask

  initial begin
    logic [6:0]  aluOps [10];
    logic [31:0] instr;
    logic [63:0] addr;
    logic [2:0]  f3;
    int kind;
    aluOps = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h13, 7'h33, 7'h1B, 7'h3B, 7'h73, 7'h63};
    tests = 0;
    errors = 0;
    RSTn = 1'b0;
    bus.IVALID = 1'b0; bus.IPC = '0; bus.IINSTR = '0; bus.IRD = '0; bus.IRS2 = '0;
    bus.ICSRD = '0; bus.DACK = 1'b0; bus.DRVALID = 1'b0; bus.DRDATA = '0;
    #13;
    checkOutput("rstIready", bus.IREADY, 1);
    checkOutput("rstDreq", bus.DREQ, 0);
    checkOutput("rstValid", bus.WB_OVALID, 0);
    checkOutput("rstOrd", bus.WB_ORD, 0);
    checkOutput("rstDstrb", bus.DSTRB, 0);
    checkOutput("rstMisalign", bus.MISALIGN, 0);
    @(negedge CLK);
    RSTn = 1'b1;
    stepClock();

    // ADDI x5,x0,42
    applyStimulus(32'h02A00293, 64'h100, 64'h2A, 64'h0, 64'h11, 0, 0, 64'h0, 1'b0);
    // SB at 0x1003, acknowledged three cycles late
    applyStimulus(mkInstr(7'h23, 3'b000), 64'h104, 64'h1003, 64'hAB, 64'h0, 3, 0, 64'h0, 1'b0);
    // LB / LBU at 0x1005
    applyStimulus(mkInstr(7'h03, 3'b000), 64'h108, 64'h1005, 64'h0, 64'h0, 1, 2, 64'h0000800000000000, 1'b0);
    checkOutput("lbValue", bus.WB_ORD, 64'hFFFFFFFFFFFFFF80);
    applyStimulus(mkInstr(7'h03, 3'b100), 64'h10C, 64'h1005, 64'h0, 64'h0, 0, 1, 64'h0000800000000000, 1'b0);
    checkOutput("lbuValue", bus.WB_ORD, 64'h80);
    // Misaligned LW at 0x1002
    applyStimulus(mkInstr(7'h03, 3'b010), 64'h110, 64'h1002, 64'h0, 64'h0, 0, 0, 64'h0, 1'b0);

    // Reset while waiting for load data, then a stale DRVALID
    bus.IVALID = 1'b1; bus.IINSTR = mkInstr(7'h03, 3'b011); bus.IRD = 64'h2000; bus.IPC = 64'h114;
    stepClock();
    bus.IVALID = 1'b0; bus.DACK = 1'b1;
    stepClock();
    bus.DACK = 1'b0;
    #2 RSTn = 1'b0;
    #1;
    checkOutput("midRstDreq", bus.DREQ, 0);
    checkOutput("midRstValid", bus.WB_OVALID, 0);
    checkOutput("midRstIready", bus.IREADY, 1);
    checkOutput("midRstOrd", bus.WB_ORD, 0);
    checkOutput("midRstDaddr", bus.DADDR, 0);
    @(negedge CLK);
    RSTn = 1'b1;
    bus.DRVALID = 1'b1; bus.DRDATA = 64'hDEADBEEF;
    stepClock();
    bus.DRVALID = 1'b0;
    checkOutput("lateRvIgnored", bus.WB_OVALID, 0);
    checkOutput("postRstIready", bus.IREADY, 1);
    checkOutput("postRstDreq", bus.DREQ, 0);

    // Three back-to-back ADDs, then LD with immediate DACK and DRVALID
    applyStimulus(mkInstr(7'h33, 3'b000), 64'h200, 64'h1, 64'h0, 64'h0, 0, 0, 64'h0, 1'b1);
    applyStimulus(mkInstr(7'h33, 3'b000), 64'h204, 64'h2, 64'h0, 64'h0, 0, 0, 64'h0, 1'b1);
    applyStimulus(mkInstr(7'h33, 3'b000), 64'h208, 64'h3, 64'h0, 64'h0, 0, 0, 64'h0, 1'b1);
    applyStimulus(mkInstr(7'h03, 3'b011), 64'h20C, 64'h3000, 64'h0, 64'h0, 0, 0, 64'h0123456789ABCDEF, 1'b0);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 4);
      addr = {$urandom, $urandom};
      if (kind == 0) begin
        f3 = 3'($urandom);
        instr = mkInstr(aluOps[$urandom_range(0, 9)], f3);
      end else begin
        if (kind <= 2) f3 = 3'($urandom_range(0, 6));
        else           f3 = 3'($urandom_range(0, 3));
        instr = mkInstr(kind <= 2 ? 7'h03 : 7'h23, f3);
        if ($urandom_range(0, 3) != 0) addr = addr & ~(64'(refBytes(f3)) - 64'd1);
      end
      applyStimulus(instr, {$urandom, $urandom}, addr, {$urandom, $urandom}, {$urandom, $urandom},
                    $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom}, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
